// File: rtl/mips_mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies,
// FSM state type and the decode-side MD-instruction predicate.
package mips_mdu_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // True for every op that must stall in ID while the unit is busy.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op >= MDU_MULT) && (op <= MDU_MTLO);
    endfunction

endpackage

// File: rtl/mips_mdu_calc.sv
// Combinational multiply/divide datapath: produces the 64-bit {hi,lo} result
// for MULT/MULTU/DIV/DIVU and flags a zero divisor.
module mips_mdu_calc
    import mips_mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [63:0] res,
    output logic        div_by_zero
);

    logic signed [63:0] smul_s;
    logic [63:0]        umul_s;
    logic [31:0]        a_mag_s;
    logic [31:0]        b_mag_s;
    logic [31:0]        u_den_s;
    logic [31:0]        s_den_s;
    logic [31:0]        uq_s;
    logic [31:0]        ur_s;
    logic [31:0]        sq_mag_s;
    logic [31:0]        sr_mag_s;
    logic [31:0]        sq_s;
    logic [31:0]        sr_s;

    assign smul_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    assign umul_s = {32'h0, rs_data} * {32'h0, rt_data};

    // Signed divide works on magnitudes; 0x80000000 keeps its magnitude as an
    // unsigned value, so MIN/-1 wraps back to 0x80000000 without special casing.
    assign a_mag_s = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
    assign b_mag_s = rt_data[31] ? (~rt_data + 32'd1) : rt_data;

    // A zero divisor is replaced by one so the datapath never produces X; the
    // result is discarded by the control logic anyway.
    assign u_den_s  = (rt_data == 32'h0) ? 32'd1 : rt_data;
    assign s_den_s  = (b_mag_s == 32'h0) ? 32'd1 : b_mag_s;
    assign uq_s     = rs_data / u_den_s;
    assign ur_s     = rs_data % u_den_s;
    assign sq_mag_s = a_mag_s / s_den_s;
    assign sr_mag_s = a_mag_s % s_den_s;
    assign sq_s     = (rs_data[31] ^ rt_data[31]) ? (~sq_mag_s + 32'd1) : sq_mag_s;
    assign sr_s     = rs_data[31] ? (~sr_mag_s + 32'd1) : sr_mag_s;

    // Result and zero-divisor selection by op.
    always_comb begin
        res         = 64'h0;
        div_by_zero = 1'b0;
        case (op)
            MDU_MULT:  res = smul_s;
            MDU_MULTU: res = umul_s;
            MDU_DIV: begin
                res         = {sr_s, sq_s};
                div_by_zero = (rt_data == 32'h0);
            end
            MDU_DIVU: begin
                res         = {ur_s, uq_s};
                div_by_zero = (rt_data == 32'h0);
            end
            default: begin
                res         = 64'h0;
                div_by_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, latches the result at start and
// commits it after a fixed latency while busy is raised.
module mips_mdu
    import mips_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  state_r, state_nx_s;
    logic [3:0]  cnt_r, cnt_nx_s;
    logic [63:0] res_r, res_nx_s;
    logic        dbz_r, dbz_nx_s;
    logic [31:0] hi_nx_s, lo_nx_s;
    logic [63:0] calc_res_s;
    logic        calc_dbz_s;

    mips_mdu_calc u_calc (
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .res         (calc_res_s),
        .div_by_zero (calc_dbz_s)
    );

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        res_nx_s   = res_r;
        dbz_nx_s   = dbz_r;
        hi_nx_s    = hi;
        lo_nx_s    = lo;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            res_nx_s   = calc_res_s;
                            dbz_nx_s   = 1'b0;
                            cnt_nx_s   = 4'(MULT_CYCLES);
                            state_nx_s = ST_RUN;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            res_nx_s   = calc_res_s;
                            dbz_nx_s   = calc_dbz_s;
                            cnt_nx_s   = 4'(DIV_CYCLES);
                            state_nx_s = ST_RUN;
                        end
                        MDU_MTHI: hi_nx_s = rs_data;
                        MDU_MTLO: lo_nx_s = rs_data;
                        default:  state_nx_s = ST_IDLE;
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // start is ignored here; the hazard unit must hold MD ops in ID.
                if (cnt_r == 4'd1) begin
                    cnt_nx_s   = 4'd0;
                    state_nx_s = ST_IDLE;
                    if (!dbz_r) begin
                        hi_nx_s = res_r[63:32];
                        lo_nx_s = res_r[31:0];
                    end else begin
                        hi_nx_s = hi;
                        lo_nx_s = lo;
                    end
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State and architectural register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            res_r   <= 64'h0;
            dbz_r   <= 1'b0;
            busy    <= 1'b0;
            hi      <= 32'h0;
            lo      <= 32'h0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            res_r   <= res_nx_s;
            dbz_r   <= dbz_nx_s;
            busy    <= (state_nx_s == ST_RUN);
            hi      <= hi_nx_s;
            lo      <= lo_nx_s;
        end
    end

endmodule

// File: tb/tb_mips_mdu.sv
// Directed self-checking bench for mips_mdu with hand-computed HI/LO results
// and busy-length checks.
module tb_mips_mdu;
    import mips_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    mips_mdu dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    // Pulse start for one edge; operands are scrambled afterwards.
    task automatic do_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        op      = MDU_NONE;
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    // Counts busy cycles from the current falling edge until busy drops.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int ncyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        do_start(o, a, b);
        wait_idle(n);
        chk({tag, "_busy"}, 32'(n), 32'(ncyc));
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = MDU_NONE; rs_data = 32'h0; rt_data = 32'h0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rst_busy", {31'h0, busy}, 32'h0);
            chk("rst_hi", hi, 32'h0);
            chk("rst_lo", lo, 32'h0);
            @(negedge clk);
        end

        run_op("mult",   MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu",  MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE);
        run_op("multm1", MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001);
        run_op("multum", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
        run_op("div",    MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divneg", MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu",   MDU_DIVU,  32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003);
        run_op("divovf", MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

        do_start(MDU_MTHI, 32'h11111111, 32'h0);
        chk("mthi_busy", {31'h0, busy}, 32'h0);
        chk("mthi_hi", hi, 32'h11111111);
        chk("mthi_lo", lo, 32'h80000000);
        do_start(MDU_MTLO, 32'h22222222, 32'h0);
        chk("mtlo_busy", {31'h0, busy}, 32'h0);
        chk("mtlo_hi", hi, 32'h11111111);
        chk("mtlo_lo", lo, 32'h22222222);

        do_start(MDU_NONE, 32'hDEADBEEF, 32'h1);
        chk("none_busy", {31'h0, busy}, 32'h0);
        chk("none_hi", hi, 32'h11111111);
        do_start(3'd7, 32'hDEADBEEF, 32'h1);
        chk("undef_busy", {31'h0, busy}, 32'h0);
        chk("undef_lo", lo, 32'h22222222);

        run_op("divu0", MDU_DIVU, 32'h12345678, 32'h0, 10, 32'h11111111, 32'h22222222);
        run_op("div0",  MDU_DIV,  32'h87654321, 32'h0, 10, 32'h11111111, 32'h22222222);

        // Second start during busy cycle 2 must be dropped.
        do_start(MDU_MULT, 32'h00010001, 32'h00030000);
        chk("ign_busy1", {31'h0, busy}, 32'h1);
        @(negedge clk);
        start = 1'b1; op = MDU_DIV; rs_data = 32'd100; rt_data = 32'd7;
        @(negedge clk);
        start = 1'b0; op = MDU_NONE;
        wait_idle(n);
        chk("ign_rest", 32'(n), 32'd3);
        chk("ign_hi", hi, 32'h00000003);
        chk("ign_lo", lo, 32'h00030000);

        // Reset on busy cycle 4 aborts the divide.
        do_start(MDU_DIV, 32'd100, 32'd7);
        chk("abort_busy1", {31'h0, busy}, 32'h1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("late_busy", {31'h0, busy}, 32'h0);
            chk("late_hi", hi, 32'h0);
            chk("late_lo", lo, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
